noc_output_allocator: RTL and testbench
=======================================

# noc_output_allocator

Per-output-port allocator and credit tracker for the NoC router. It shares one router output link among `NUM_INPUTS` input-buffer requesters using round-robin arbitration, and holds the grant for the full length of a wormhole packet (head to tail flit). It counts downstream buffer credits so that no flit is ever sent without buffer space, and it registers the chosen flit onto the link. One instance sits on each router output, between the input flit buffers and the link or local deserializer shim.

## Interface
Parameters:
- `NUM_INPUTS`, default 5: number of requesting input ports (index 0 = local injection).
- `FLIT_WIDTH`, default 128: flit payload width.
- `DEST_WIDTH`, default 6: destination field width.
- `FLIT_BUFFER_DEPTH`, default 4: downstream buffer depth; initial credit count.
- `CNT_W`, default `$clog2(FLIT_BUFFER_DEPTH+1)`: credit counter width (derived).

Ports:
- `clk_noc`  in  1  NoC clock. One clock only: all logic is on `clk_noc`, reset is asynchronous and active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  `[NUM_INPUTS]`  input i has a flit at its buffer head.
- `req_data`  in  `[NUM_INPUTS][FLIT_WIDTH]`  head flit payload per input.
- `req_dest`  in  `[NUM_INPUTS][DEST_WIDTH]`  head flit destination per input.
- `req_is_tail`  in  `[NUM_INPUTS]`  head flit is the tail of its packet.
- `grant`  out  `[NUM_INPUTS]`  one-hot, combinational; the flit at input i is consumed (popped) this cycle.
- `data_out`  out  `FLIT_WIDTH`  registered link data.
- `dest_out`  out  `DEST_WIDTH`  registered link destination.
- `is_tail_out`  out  1  registered tail marker.
- `send_out`  out  1  registered flit-valid strobe.
- `credit_in`  in  1  one pulse returns one downstream buffer slot.
- `credit_count`  out  `CNT_W`  current credit count.
- `locked`  out  1  a packet is in progress (LOCKED state).
- `credit_overflow`  out  1  sticky error flag.

## Operation
- FSM has two states, IDLE and LOCKED, with a lock-owner register `owner` (`$clog2(NUM_INPUTS)` bits) and a round-robin pointer `rr_ptr`.
- Eligibility: a grant can only be issued when `credit_count > 0`.
- **IDLE:**
  - The winner is the first i with `req[i]=1`, searching from `rr_ptr` upward with wrap-around.
  - If the winner's `req_is_tail=0`: go to LOCKED with `owner` = winner.
  - If the winner's `req_is_tail=1` (single-flit packet): stay in IDLE.
- **LOCKED:**
  - Only `owner` can be granted, and only when `req[owner]=1`. Every other request is ignored.
  - When the owner's tail flit is granted: go to IDLE.
  - Bubbles (`req[owner]=0`) keep the lock.
- Pointer update: on every granted tail flit from input i, `rr_ptr` ← (i+1) mod `NUM_INPUTS`. `rr_ptr` is unchanged otherwise.
- At most one `grant` bit is set per cycle. `grant` is all-zero when there are no credits.
- Credit counter:
  - grant without `credit_in`: decrement.
  - `credit_in` without grant: increment.
  - Both in the same cycle: unchanged.
  - `credit_in` while the count is already `FLIT_BUFFER_DEPTH` (with no grant): count saturates, and `credit_overflow` is set and stays set until reset.
- Datapath: on a grant, `data_out`, `dest_out` and `is_tail_out` load from the granted input on the next edge, and `send_out`=1 for exactly one cycle. With no grant, `send_out`=0 and the data registers hold their values.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `owner`=0
  - `credit_count`=`FLIT_BUFFER_DEPTH`
  - `send_out`=0, `is_tail_out`=0, `data_out`=0, `dest_out`=0
  - `locked`=0, `credit_overflow`=0
- `grant` is combinational from `req`, state and `credit_count` in the same cycle, with no latency.
- `send_out` rises one cycle after `grant` (1-cycle latency). Sustained throughput is 1 flit/cycle while credits last.
- A `credit_in` pulse in cycle t makes a grant possible in cycle t+1 (counter is registered). There is no same-cycle credit bypass.
- `locked` reflects the registered state. It is 1 from the cycle after a non-tail head is granted through the cycle in which its tail is granted.
- Reset asserted mid-packet: the lock is dropped immediately (asynchronous), and credits are restored to `FLIT_BUFFER_DEPTH`. Upstream and downstream buffers are reset by the same `rst_n`.

## Test plan
- **Basic send.** Reset, then `req[2]=1` with a tail flit, data 0xA5. Expect `grant`=00100 in the same cycle, `send_out`=1 with `data_out`=0xA5 on the next cycle, `credit_count` 4→3, `rr_ptr`=3.
- **Wormhole lock.** Input 1 sends a 3-flit packet while input 3 requests continuously. Expect 3 consecutive grants to input 1, then input 3. `locked`=1 for exactly the cycles covering the first and second flits.
- **Fairness.** All 5 inputs request single-flit packets with credits replenished every cycle. Expect grant order 0,1,2,3,4,0.
- **Credit exhaustion.** No `credit_in`, 6 single-flit requests. Expect 4 grants, then `grant`=0 with `credit_count`=0. A single `credit_in` pulse then gives exactly one grant one cycle later.
- **Simultaneous grant and credit.** Grant and `credit_in` in the same cycle at count 2 keep the count at 2. An extra `credit_in` at count 4 sets `credit_overflow`=1 and holds the count at 4.
- **Mid-packet reset.** Drop `rst_n` during the second flit of a 4-flit packet. Expect `send_out`=0, `locked`=0, `credit_count`=4 immediately. After release, a different input wins from `rr_ptr`=0.

Source files
------------

// File: rtl/noc_output_allocator.sv
// Output-port allocator: round-robin arbitration with wormhole lock, downstream
// credit tracking, and a registered link stage for the granted flit.
module noc_output_allocator #(
    parameter int NUM_INPUTS        = 5,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int CNT_W             = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                             clk_noc,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS-1:0]            req,
    input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] req_data,
    input  logic [NUM_INPUTS*DEST_WIDTH-1:0] req_dest,
    input  logic [NUM_INPUTS-1:0]            req_is_tail,
    output logic [NUM_INPUTS-1:0]            grant,
    output logic [FLIT_WIDTH-1:0]            data_out,
    output logic [DEST_WIDTH-1:0]            dest_out,
    output logic                             is_tail_out,
    output logic                             send_out,
    input  logic                             credit_in,
    output logic [CNT_W-1:0]                 credit_count,
    output logic                             locked,
    output logic                             credit_overflow
);

    localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FLIT_BUFFER_DEPTH);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    logic             overflow_q, overflow_d;

    logic                  send_q;
    logic [FLIT_WIDTH-1:0] data_q;
    logic [DEST_WIDTH-1:0] dest_q;
    logic                  tail_q;

    logic                  hi_found, lo_found;
    logic [IDX_W-1:0]      hi_idx, lo_idx, sel_idx;
    logic                  sel_valid, grant_en;
    logic [FLIT_WIDTH-1:0] sel_data;
    logic [DEST_WIDTH-1:0] sel_dest;
    logic                  sel_tail;

    // Round-robin search split into two passes: requesters at or above
    // rr_ptr take priority, otherwise the lowest index wraps around.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        if (state_q == LOCKED) begin
            sel_idx   = owner_q;
            sel_valid = req[owner_q];
        end else if (hi_found) begin
            sel_idx   = hi_idx;
            sel_valid = 1'b1;
        end else begin
            sel_idx   = lo_idx;
            sel_valid = lo_found;
        end
        grant_en = sel_valid && (credit_q != '0);
    end

    always_comb begin
        grant    = '0;
        sel_data = '0;
        sel_dest = '0;
        sel_tail = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_en && (sel_idx == IDX_W'(i))) begin
                grant[i] = 1'b1;
                sel_data = req_data[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_dest = req_dest[i*DEST_WIDTH +: DEST_WIDTH];
                sel_tail = req_is_tail[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        credit_d   = credit_q;
        overflow_d = overflow_q;
        if (grant_en) begin
            if (sel_tail) begin
                state_d  = IDLE;
                rr_ptr_d = (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
            end else if (state_q == IDLE) begin
                state_d = LOCKED;
                owner_d = sel_idx;
            end
        end
        // A returned credit and a sent flit in the same cycle cancel out.
        if (grant_en && !credit_in) begin
            credit_d = credit_q - CNT_W'(1);
        end else if (!grant_en && credit_in) begin
            if (credit_q == CREDIT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                credit_d = credit_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            credit_q   <= CREDIT_MAX;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_noc or negedge rst_n) begin
        if (!rst_n) begin
            send_q <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
            tail_q <= 1'b0;
        end else begin
            send_q <= grant_en;
            if (grant_en) begin
                data_q <= sel_data;
                dest_q <= sel_dest;
                tail_q <= sel_tail;
            end
        end
    end

    assign data_out        = data_q;
    assign dest_out        = dest_q;
    assign is_tail_out     = tail_q;
    assign send_out        = send_q;
    assign credit_count    = credit_q;
    assign locked          = (state_q == LOCKED);
    assign credit_overflow = overflow_q;

endmodule

// File: tb/tb_noc_output_allocator.sv
// Self-checking bench for noc_output_allocator: directed scenarios plus a
// randomized run against a packet-level reference model.
module tb_noc_output_allocator;

    localparam int N     = 5;
    localparam int FW    = 128;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    // ---------------- clock / reset / DUT ----------------
    logic              clk_noc;
    logic              rst_n;
    logic [N-1:0]      req;
    logic [N*FW-1:0]   req_data;
    logic [N*DW-1:0]   req_dest;
    logic [N-1:0]      req_is_tail;
    logic [N-1:0]      grant;
    logic [FW-1:0]     data_out;
    logic [DW-1:0]     dest_out;
    logic              is_tail_out;
    logic              send_out;
    logic              credit_in;
    logic [CW-1:0]     credit_count;
    logic              locked;
    logic              credit_overflow;

    noc_output_allocator #(
        .NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk_noc), .rst_n(rst_n), .req(req), .req_data(req_data),
        .req_dest(req_dest), .req_is_tail(req_is_tail), .grant(grant),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
        .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
        .locked(locked), .credit_overflow(credit_overflow)
    );

    initial clk_noc = 1'b0;
    always #5 clk_noc = ~clk_noc;

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- reference model + scoreboard ----------------
    int checks = 0;
    int errors = 0;

    int          m_credits;
    int          m_owner;      // -1 when no packet holds the link
    int          m_ptr;
    bit          m_ovf;
    bit          m_send;
    bit          m_tail;
    logic [FW-1:0] m_data;
    logic [DW-1:0] m_dest;
    logic [N-1:0]  exp_grant;

    logic [FW+DW:0] exp_q[$];  // {tail, dest, data} of each granted flit

    logic [N-1:0]  obs_grant;
    logic          obs_send, obs_tail, obs_locked, obs_ovf;
    logic [FW-1:0] obs_data;
    logic [DW-1:0] obs_dest;
    logic [CW-1:0] obs_credit;

    task automatic model_reset();
        m_credits = DEPTH;
        m_owner   = -1;
        m_ptr     = 0;
        m_ovf     = 1'b0;
        m_send    = 1'b0;
        m_tail    = 1'b0;
        m_data    = '0;
        m_dest    = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n       = 1'b0;
        req         = '0;
        req_is_tail = '0;
        credit_in   = 1'b0;
        repeat (2) @(negedge clk_noc);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic set_in(input int i, input bit r, input bit t,
                          input logic [FW-1:0] d, input logic [DW-1:0] ds);
        req[i]                = r;
        req_is_tail[i]        = t;
        req_data[i*FW +: FW]  = d;
        req_dest[i*DW +: DW]  = ds;
    endtask

    function automatic logic [FW-1:0] rand_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge with inputs already applied. Captures the
    // combinational grant, advances the model one cycle, then captures the
    // registered outputs just after the rising edge.
    task automatic tick();
        int g;
        int idx;
        #1;
        obs_grant = grant;
        g = -1;
        if (m_credits > 0) begin
            if (m_owner >= 0) begin
                if (req[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (g < 0 && req[idx]) g = idx;
                end
            end
        end
        exp_grant = '0;
        m_send    = (g >= 0);
        if (g >= 0) begin
            exp_grant[g] = 1'b1;
            m_data = req_data[g*FW +: FW];
            m_dest = req_dest[g*DW +: DW];
            m_tail = req_is_tail[g];
            exp_q.push_back({m_tail, m_dest, m_data});
            if (m_tail) begin
                m_owner = -1;
                m_ptr   = (g + 1) % N;
            end else begin
                m_owner = g;
            end
            if (!credit_in) m_credits--;
        end else if (credit_in) begin
            if (m_credits == DEPTH) m_ovf = 1'b1;
            else m_credits++;
        end
        @(posedge clk_noc);
        #1;
        obs_send   = send_out;
        obs_data   = data_out;
        obs_dest   = dest_out;
        obs_tail   = is_tail_out;
        obs_credit = credit_count;
        obs_locked = locked;
        obs_ovf    = credit_overflow;
        @(negedge clk_noc);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_is_tail = '0; credit_in = 1'b0;
        req_data = '0; req_dest = '0;
        model_reset();
        @(negedge clk_noc);
        #1;
        checks++; if (send_out !== 1'b0) begin errors++; $display("FAIL reset_send got=%b exp=0", send_out); end
        checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data got=%0h exp=0", data_out); end
        checks++; if (dest_out !== '0) begin errors++; $display("FAIL reset_dest got=%0h exp=0", dest_out); end
        checks++; if (is_tail_out !== 1'b0) begin errors++; $display("FAIL reset_tail got=%b exp=0", is_tail_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (credit_count !== CW'(DEPTH)) begin errors++; $display("FAIL reset_credit got=%0d exp=%0d", credit_count, DEPTH); end
        checks++; if (credit_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", credit_overflow); end
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        rst_n = 1'b1;
        @(negedge clk_noc);
    endtask

    task automatic test_basic_send();
        req = '0; credit_in = 1'b0;
        set_in(2, 1'b1, 1'b1, 128'hA5, 6'd9);
        tick();
        checks++; if (obs_grant !== 5'b00100) begin errors++; $display("FAIL basic_grant got=%b exp=00100", obs_grant); end
        checks++; if (obs_send !== 1'b1) begin errors++; $display("FAIL basic_send got=%b exp=1", obs_send); end
        checks++; if (obs_data !== 128'hA5) begin errors++; $display("FAIL basic_data got=%0h exp=a5", obs_data); end
        checks++; if (obs_dest !== 6'd9 || obs_tail !== 1'b1) begin errors++; $display("FAIL basic_dest_tail got=%0d/%b exp=9/1", obs_dest, obs_tail); end
        checks++; if (obs_credit !== CW'(3)) begin errors++; $display("FAIL basic_credit got=%0d exp=3", obs_credit); end
        // rr_ptr should now be 3: input 3 beats 0, 1 and 4
        req = '0;
        for (int i = 0; i < N; i++) if (i != 2) set_in(i, 1'b1, 1'b1, rand_flit(), DW'($urandom));
        tick();
        checks++; if (obs_grant !== 5'b01000) begin errors++; $display("FAIL basic_rrptr got=%b exp=01000", obs_grant); end
        req = '0; credit_in = 1'b1;
        repeat (2) tick();
        credit_in = 1'b0;
        checks++; if (obs_send !== 1'b0 || obs_data !== m_data) begin errors++; $display("FAIL basic_hold got=%b/%0h exp=0/%0h", obs_send, obs_data, m_data); end
        checks++; if (obs_credit !== CW'(DEPTH)) begin errors++; $display("FAIL basic_refill got=%0d exp=%0d", obs_credit, DEPTH); end
    endtask

    task automatic test_wormhole();
        logic [N-1:0] wh_grant[4] = '{5'b00010, 5'b00010, 5'b00010, 5'b01000};
        bit           wh_lock[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        req = '0; credit_in = 1'b1;
        set_in(3, 1'b1, 1'b1, rand_flit(), 6'd33);
        for (int f = 0; f < 4; f++) begin
            if (f < 3) set_in(1, 1'b1, (f == 2), rand_flit(), 6'd17);
            else       set_in(1, 1'b0, 1'b0, '0, '0);
            tick();
            checks++; if (obs_grant !== wh_grant[f]) begin errors++; $display("FAIL wormhole_grant[%0d] got=%b exp=%b", f, obs_grant, wh_grant[f]); end
            checks++; if (obs_locked !== wh_lock[f]) begin errors++; $display("FAIL wormhole_locked[%0d] got=%b exp=%b", f, obs_locked, wh_lock[f]); end
        end
        req = '0; credit_in = 1'b0;
    endtask

    task automatic test_fairness();
        logic [N-1:0] e;
        do_reset();
        for (int i = 0; i < N; i++) set_in(i, 1'b1, 1'b1, rand_flit(), DW'(i));
        credit_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            e = '0;
            e[c % N] = 1'b1;
            tick();
            checks++; if (obs_grant !== e) begin errors++; $display("FAIL fairness_order[%0d] got=%b exp=%b", c, obs_grant, e); end
            checks++; if (obs_dest !== DW'(c % N)) begin errors++; $display("FAIL fairness_dest[%0d] got=%0d exp=%0d", c, obs_dest, c % N); end
        end
        checks++; if (obs_credit !== CW'(DEPTH)) begin errors++; $display("FAIL fairness_credit got=%0d exp=%0d", obs_credit, DEPTH); end
        req = '0; credit_in = 1'b0;
    endtask

    task automatic test_credit_exhaustion();
        logic [N-1:0] e;
        do_reset();
        set_in(0, 1'b1, 1'b1, rand_flit(), 6'd1);
        for (int c = 0; c < 6; c++) begin
            e = (c < 4) ? 5'b00001 : 5'b00000;
            tick();
            checks++; if (obs_grant !== e) begin errors++; $display("FAIL exhaust_grant[%0d] got=%b exp=%b", c, obs_grant, e); end
            checks++; if (obs_credit !== CW'((c < 4) ? 3 - c : 0)) begin errors++; $display("FAIL exhaust_credit[%0d] got=%0d exp=%0d", c, obs_credit, (c < 4) ? 3 - c : 0); end
        end
        credit_in = 1'b1;
        tick();
        checks++; if (obs_grant !== 5'b00000) begin errors++; $display("FAIL exhaust_no_bypass got=%b exp=00000", obs_grant); end
        credit_in = 1'b0;
        tick();
        checks++; if (obs_grant !== 5'b00001 || obs_credit !== CW'(0)) begin errors++; $display("FAIL exhaust_one_grant got=%b/%0d exp=00001/0", obs_grant, obs_credit); end
        tick();
        checks++; if (obs_grant !== 5'b00000) begin errors++; $display("FAIL exhaust_after got=%b exp=00000", obs_grant); end
        req = '0;
    endtask

    task automatic test_simultaneous();
        req = '0; credit_in = 1'b1;
        repeat (2) tick();
        checks++; if (obs_credit !== CW'(2)) begin errors++; $display("FAIL simul_setup got=%0d exp=2", obs_credit); end
        set_in(0, 1'b1, 1'b1, rand_flit(), 6'd4);
        tick();
        checks++; if (obs_grant !== 5'b00001 || obs_credit !== CW'(2)) begin errors++; $display("FAIL simul_cancel got=%b/%0d exp=00001/2", obs_grant, obs_credit); end
        req = '0;
        repeat (2) tick();
        checks++; if (obs_credit !== CW'(4) || obs_ovf !== 1'b0) begin errors++; $display("FAIL simul_full got=%0d/%b exp=4/0", obs_credit, obs_ovf); end
        tick();
        checks++; if (obs_credit !== CW'(4) || obs_ovf !== 1'b1) begin errors++; $display("FAIL simul_overflow got=%0d/%b exp=4/1", obs_credit, obs_ovf); end
        credit_in = 1'b0;
        set_in(0, 1'b1, 1'b1, rand_flit(), 6'd5);
        tick();
        checks++; if (obs_ovf !== 1'b1 || obs_credit !== CW'(3)) begin errors++; $display("FAIL simul_sticky got=%b/%0d exp=1/3", obs_ovf, obs_credit); end
        req = '0;
    endtask

    task automatic test_mid_reset();
        logic [FW-1:0] d1;
        do_reset();
        set_in(2, 1'b1, 1'b0, rand_flit(), 6'd2);
        tick();
        checks++; if (obs_grant !== 5'b00100 || obs_locked !== 1'b1) begin errors++; $display("FAIL midrst_head got=%b/%b exp=00100/1", obs_grant, obs_locked); end
        set_in(2, 1'b1, 1'b0, rand_flit(), 6'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (send_out !== 1'b0) begin errors++; $display("FAIL midrst_send got=%b exp=0", send_out); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got=%b exp=0", locked); end
        checks++; if (credit_count !== CW'(DEPTH)) begin errors++; $display("FAIL midrst_credit got=%0d exp=%0d", credit_count, DEPTH); end
        @(negedge clk_noc);
        rst_n = 1'b1;
        model_reset();
        req = '0;
        d1 = rand_flit();
        set_in(1, 1'b1, 1'b1, d1, 6'd11);
        set_in(3, 1'b1, 1'b1, rand_flit(), 6'd13);
        tick();
        checks++; if (obs_grant !== 5'b00010) begin errors++; $display("FAIL midrst_winner got=%b exp=00010", obs_grant); end
        checks++; if (obs_data !== d1) begin errors++; $display("FAIL midrst_data got=%0h exp=%0h", obs_data, d1); end
        req = '0;
    endtask

    task automatic test_random();
        int rem[N];
        logic [FW+DW:0] exp_flit;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 4);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                set_in(i, ($urandom_range(0, 3) != 0), (rem[i] == 1), rand_flit(), DW'($urandom));
            end
            credit_in = (m_credits < DEPTH) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
            tick();
            checks++; if (obs_grant !== exp_grant) begin errors++; $display("FAIL rand_grant[%0d] got=%b exp=%b", c, obs_grant, exp_grant); end
            checks++; if (obs_send !== m_send) begin errors++; $display("FAIL rand_send[%0d] got=%b exp=%b", c, obs_send, m_send); end
            checks++; if (obs_credit !== CW'(m_credits)) begin errors++; $display("FAIL rand_credit[%0d] got=%0d exp=%0d", c, obs_credit, m_credits); end
            checks++; if (obs_locked !== (m_owner >= 0)) begin errors++; $display("FAIL rand_locked[%0d] got=%b exp=%b", c, obs_locked, (m_owner >= 0)); end
            checks++; if (obs_ovf !== m_ovf) begin errors++; $display("FAIL rand_ovf[%0d] got=%b exp=%b", c, obs_ovf, m_ovf); end
            if (obs_send === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_flit[%0d] got=send exp=no_flit", c);
                end else begin
                    exp_flit = exp_q.pop_front();
                    if ({obs_tail, obs_dest, obs_data} !== exp_flit) begin
                        errors++; $display("FAIL rand_flit[%0d] got=%0h exp=%0h", c, {obs_tail, obs_dest, obs_data}, exp_flit);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (exp_grant[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                end
            end
        end
        req = '0; credit_in = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_send();
        test_wormhole();
        test_fairness();
        test_credit_exhaustion();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
